// File: rtl/mintz80_pkg.sv
// Shared types and constants for the MinTZ80 MMU wait-state logic.
package mintz80_pkg;

    // Wait controller FSM states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } wsc_state_t;

    // I/O port map for the wait-state config register and slow external ports
    localparam logic [7:0] IO_WSCFG  = 8'hD2;
    localparam logic [7:0] IO_EXT_LO = 8'hD4;
    localparam logic [7:0] IO_EXT_HI = 8'hD7;

    // Field index of each wait count inside the cfg word (field * WS_W = LSB)
    localparam int CFG_ROM_FIELD = 0;
    localparam int CFG_IO_FIELD  = 1;

endpackage

// File: rtl/wsc_cfg_reg.sv
// Lockable wait-state config register; loads once per I/O write to $D2.
module wsc_cfg_reg
    import mintz80_pkg::*;
#(
    parameter int WS_W       = 2,
    parameter int ROM_WS_RST = 1,
    parameter int IO_WS_RST  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_sel,
    input  logic                iorq_n,
    input  logic                wr_n,
    input  logic                cfg_lock,
    input  logic [2*WS_W-1:0]   din,
    output logic [2*WS_W-1:0]   cfg_q
);

    localparam logic [WS_W-1:0] ROM_RST = ROM_WS_RST[WS_W-1:0];
    localparam logic [WS_W-1:0] IO_RST  = IO_WS_RST[WS_W-1:0];

    logic wr_cfg;
    logic wr_cfg_d;

    assign wr_cfg = cfg_sel & ~iorq_n & ~wr_n & ~cfg_lock;

    // Load din only on the first clock of a qualified write so a long
    // write strobe with a changing bus captures the value exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cfg_d <= 1'b0;
            cfg_q[CFG_ROM_FIELD*WS_W +: WS_W] <= ROM_RST;
            cfg_q[CFG_IO_FIELD*WS_W +: WS_W]  <= IO_RST;
        end else begin
            wr_cfg_d <= wr_cfg;
            if (wr_cfg && !wr_cfg_d) begin
                cfg_q <= din;
            end
        end
    end

endmodule

// File: rtl/z80_wait_ctrl.sv
// Z80 wait-state controller: stretches ROM and external I/O bus cycles.
module z80_wait_ctrl
    import mintz80_pkg::*;
#(
    parameter int WS_W       = 2,
    parameter int ROM_WS_RST = 1,
    parameter int IO_WS_RST  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mreq_n,
    input  logic                iorq_n,
    input  logic                m1_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                romen_n,
    input  logic                extio_n,
    input  logic                cfg_sel,
    input  logic                cfg_lock,
    input  logic [2*WS_W-1:0]   din,
    output logic                wait_n,
    output logic [2*WS_W-1:0]   cfg_q,
    output logic                busy
);

    wsc_state_t      state;
    logic [WS_W-1:0] cnt;
    logic [WS_W-1:0] rom_ws;
    logic [WS_W-1:0] io_ws;
    logic [WS_W-1:0] sel_ws;
    logic            rom_match;
    logic            io_match;
    logic            bus_idle;

    wsc_cfg_reg #(
        .WS_W       (WS_W),
        .ROM_WS_RST (ROM_WS_RST),
        .IO_WS_RST  (IO_WS_RST)
    ) u_cfg (
        .clk      (clk),
        .reset    (reset),
        .cfg_sel  (cfg_sel),
        .iorq_n   (iorq_n),
        .wr_n     (wr_n),
        .cfg_lock (cfg_lock),
        .din      (din),
        .cfg_q    (cfg_q)
    );

    assign rom_ws    = cfg_q[CFG_ROM_FIELD*WS_W +: WS_W];
    assign io_ws     = cfg_q[CFG_IO_FIELD*WS_W +: WS_W];
    assign rom_match = ~mreq_n & ~romen_n & (~rd_n | ~wr_n | ~m1_n);
    assign io_match  = ~iorq_n & m1_n & ~extio_n;
    assign sel_ws    = rom_match ? rom_ws : io_ws;
    assign bus_idle  = mreq_n & iorq_n;

    // Wait-state FSM: latch the count on a match, hold WAIT low for that many
    // clocks, then park in HOLD until the bus cycle ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wait_n <= 1'b1;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rom_match || io_match) begin
                        if (sel_ws != '0) begin
                            cnt    <= sel_ws - WS_W'(1);
                            wait_n <= 1'b0;
                            busy   <= 1'b1;
                            state  <= WAIT;
                        end else begin
                            state  <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    if (bus_idle) begin
                        wait_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt    <= cnt - WS_W'(1);
                    end else begin
                        wait_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus_idle) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wait_n <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/z80_wait_ctrl.md
Name: z80_wait_ctrl

Overview:
- Wait-state controller for the MinTZ80 MMU.
- Watches Z80 bus cycles and drives WAIT low for a programmable number of CPU clocks on slow targets: ROM memory cycles and external I/O ports $D4-$D7.
- Runs on the CPU clock produced by the MMU clock generator.
- Wait counts live in a lockable config register at I/O port $D2, so firmware can retune timing when it changes the clock divider.

Parameters:
- WS_W, 2, width of each wait-count field (max waits = 2^WS_W-1).
- ROM_WS_RST, 1, ROM wait count after reset.
- IO_WS_RST, 2, external-I/O wait count after reset.

Ports:
- clk  in  1  CPU clock (sysclk); all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- mreq_n  in  1  Z80 MREQ, active-low.
- iorq_n  in  1  Z80 IORQ, active-low.
- m1_n  in  1  Z80 M1, active-low (identifies interrupt acknowledge).
- rd_n  in  1  Z80 RD, active-low.
- wr_n  in  1  Z80 WR, active-low.
- romen_n  in  1  ROM chip select from the MMU decoder, active-low.
- extio_n  in  1  external-I/O select ($D4-$D7), active-low.
- cfg_sel  in  1  high when the I/O address decodes to $D2.
- cfg_lock  in  1  high blocks config writes (driven by the memmap lock).
- din  in  2*WS_W  data bus bits; [WS_W-1:0]=ROM count, [2*WS_W-1:WS_W]=I/O count.
- wait_n  out  1  Z80 WAIT, active-low.
- cfg_q  out  2*WS_W  current config register, for read-back mux.
- busy  out  1  high while any wait is being inserted.

Behaviour:
- Reset (async, reset=0): state=IDLE; wait_n=1; busy=0; cfg_q={IO_WS_RST,ROM_WS_RST}. Reset mid-wait releases WAIT immediately with no glitch low.
- Config write:
  - wr_cfg = cfg_sel & ~iorq_n & ~wr_n & ~cfg_lock, sampled at a rising edge.
  - Edge-detected: the register loads din once, on the first clk where wr_cfg is 1 after being 0.
  - Config writes never insert wait states.
- Access classes, sampled at a rising edge while in IDLE:
  - ROM: ~mreq_n & ~romen_n & (~rd_n | ~wr_n | ~m1_n); count = cfg ROM field.
  - EXTIO: ~iorq_n & m1_n & ~extio_n; count = cfg I/O field.
  - Interrupt acknowledge (iorq_n=0 & m1_n=0) is never a match.
  - ROM and EXTIO cannot both be valid on a Z80; if both appear, ROM wins.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE:
    - match with count>0: load cnt=count-1, wait_n<=0, busy<=1, go to WAIT.
    - match with count=0: go to HOLD, WAIT untouched.
    - no match: stay.
  - WAIT:
    - cnt>0: cnt<=cnt-1.
    - cnt=0: wait_n<=1, busy<=0, go to HOLD.
    - WAIT is therefore low for exactly `count` clk cycles.
    - If mreq_n and iorq_n both go high while in WAIT (aborted cycle): release wait_n and go to IDLE next edge.
  - HOLD: stay until mreq_n=1 and iorq_n=1 at a rising edge, then go to IDLE. This prevents re-triggering within one bus cycle.
- Count capture: the count is latched on entry to WAIT. A config write during an access affects only the next access.
- Registered outputs: wait_n and busy are registered; no combinational path from inputs.
- Back-to-back accesses: the next access needs only one IDLE sample after strobes deassert. The Z80 always deasserts MREQ/IORQ between cycles.
- Refresh cycles: mreq_n=0, rd_n=wr_n=m1_n=1, so they never match.

Decomposition:
- Package mintz80_pkg holds:
  - state enum {IDLE,WAIT,HOLD};
  - constants IO_WSCFG=8'hD2, IO_EXT_LO=8'hD4, IO_EXT_HI=8'hD7;
  - field offsets for the cfg word.
- One natural sub-module: wsc_cfg_reg. It contains the lockable config register with wr-edge detect and async reset to defaults. The FSM and counter stay in the top.

Test Plan:
- Reset defaults: pulse reset low mid-run → cfg_q=4'b1001 (IO=2, ROM=1), wait_n=1, busy=0.
- ROM read with defaults: mreq_n=0, rd_n=0, romen_n=0 → wait_n low exactly 1 clk starting 1 clk after first sample; HOLD until mreq_n=1, then IDLE.
- Ext I/O write at $D5 with defaults: iorq_n=0, wr_n=0, extio_n=0 → wait_n low exactly 2 clks. Repeat with iorq_n=0, m1_n=0 (INTA) → wait_n stays 1.
- Config write: cfg_sel=1, wr strobe, din=4'b0011, cfg_lock=0 → cfg_q=4'b0011; next ROM access 3 waits, next I/O access none. Same write with cfg_lock=1 → cfg_q unchanged.
- Config write while a ROM wait is in progress (count 3): current access still gets 3 waits; following access uses the new value.
- Abort and reset: de-assert mreq_n in WAIT state → wait_n=1 next edge, state IDLE. Assert reset during WAIT → wait_n=1 asynchronously.
